// File: rtl/store_align_buf_pkg.sv
// store_align_buf_pkg: size codes, byte-enable constants and store-buffer entry layout.
package store_align_buf_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;
    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic [3:0] BE_HI   = 4'b1100;
    localparam logic [3:0] BE_LO   = 4'b0011;
    localparam int ENT_ADDR_W = 30;
    typedef struct packed {
        logic [ENT_ADDR_W-1:0] addrW;
        logic [31:0]           wdata;
        logic [3:0]            be;
    } entryT;
endpackage

// File: rtl/store_align_buf_align.sv
// store_align: maps a store's size, low address bits and data to byte enables, lane-replicated data and a misalign flag.
module store_align
    import store_align_buf_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        misalign
);
    always_comb begin
        misalign = (size == SZ_RSVD) || (size == SZ_HALF && addrLo[0]) || (size == SZ_WORD && addrLo != 2'b00);
        be = size == SZ_BYTE ? 4'b0001 << addrLo :
             size == SZ_HALF ? (addrLo[1] ? BE_HI : BE_LO) : BE_WORD;
        wdata = size == SZ_BYTE ? {4{data[7:0]}} :
                size == SZ_HALF ? {2{data[15:0]}} : data;
    end
endmodule

// File: rtl/store_align_buf.sv
// store_align_buf: aligns SB/SH/SW requests and queues them in a FIFO that drains to data memory.
module store_align_buf
    import store_align_buf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [31:0]       st_data,
    input  logic [1:0]        st_size,
    output logic              st_misalign,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_conflict,
    output logic              buf_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    entryT             entries [DEPTH];
    entryT             head;
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [PTR_W:0]    count;
    logic [3:0]        alBe;
    logic [31:0]       alData;
    logic              alMis, accept, enq, deq;
    logic [ENT_ADDR_W-1:0] ldWord;
    logic              unusedLdBits;

    store_align u_align (
        .size(st_size),
        .addrLo(st_addr[1:0]),
        .data(st_data),
        .be(alBe),
        .wdata(alData),
        .misalign(alMis)
    );

    assign st_ready     = count != (PTR_W+1)'(DEPTH);
    assign mem_valid    = count != '0;
    assign buf_empty    = count == '0;
    assign accept       = st_valid & st_ready;
    assign enq          = accept & ~alMis;
    assign deq          = mem_valid & mem_ready;
    assign head         = entries[rdPtr];
    assign mem_addr     = {head.addrW[ADDR_W-3:0], 2'b00};
    assign mem_wdata    = head.wdata;
    assign mem_be       = head.be;
    assign ldWord       = ENT_ADDR_W'(ld_addr[ADDR_W-1:2]);
    assign unusedLdBits = ^ld_addr[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr       <= '0;
            wrPtr       <= '0;
            count       <= '0;
            st_misalign <= 1'b0;
        end else begin
            rdPtr       <= deq ? rdPtr + PTR_W'(1) : rdPtr;
            wrPtr       <= enq ? wrPtr + PTR_W'(1) : wrPtr;
            count       <= count + (PTR_W+1)'(enq) - (PTR_W+1)'(deq);
            st_misalign <= accept & alMis;
        end
    end

    // Storage needs no reset: an entry only matters once count covers it.
    always_ff @(posedge clk) begin
        if (enq)
            entries[wrPtr] <= '{addrW: ENT_ADDR_W'(st_addr[ADDR_W-1:2]), wdata: alData, be: alBe};
    end

    // An entry is live when its distance from the head is below count.
    always_comb begin
        ld_conflict = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            ld_conflict = ld_conflict | (({1'b0, PTR_W'(i) - rdPtr} < count) && entries[i].addrW == ldWord);
    end
endmodule

// File: tb/tb_store_align_buf.sv
// tb_store_align_buf: scoreboard bench with directed cases and randomized traffic against a byte-lane reference model.
module tb_store_align_buf;
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } expT;

    logic        clk = 0, reset = 1;
    logic        st_valid = 0, st_ready, st_misalign;
    logic [31:0] st_addr = 0, st_data = 0;
    logic [1:0]  st_size = 0;
    logic        mem_valid, mem_ready = 0;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr = 0;
    logic        ld_conflict, buf_empty;

    int  nChecks = 0, nFail = 0;
    expT sb[$];
    logic pendMis = 0;

    store_align_buf #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
        .st_size(st_size), .st_misalign(st_misalign),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .buf_empty(buf_empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic legal(input logic [31:0] a, input logic [1:0] s);
        return s == 2'd0 || (s == 2'd1 && a % 2 == 0) || (s == 2'd2 && a % 4 == 0);
    endfunction

    // Reference: a store of n bytes covers lanes [a%4, a%4+n); lane k carries data byte k%n.
    function automatic expT model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        expT e;
        int n = 1 << s;
        int lo = int'(a % 4);
        e.addr = a - (a % 4);
        for (int k = 0; k < 4; k++) begin
            e.be[k] = (k >= lo) && (k < lo + n);
            e.wdata[8*k +: 8] = d[8*(k % n) +: 8];
        end
        return e;
    endfunction

    function automatic logic conflictModel(input logic [31:0] la);
        foreach (sb[i]) if (sb[i].addr / 4 == la / 4) return 1'b1;
        return 1'b0;
    endfunction

    // Called just after a rising edge; occupancy of sb equals the DUT's entry count here.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                        input logic mr, input logic [31:0] la, output logic acc);
        chk("st_ready", st_ready, sb.size() < DEPTH);
        chk("mem_valid", mem_valid, sb.size() != 0);
        chk("buf_empty", buf_empty, sb.size() == 0);
        chk("st_misalign", st_misalign, pendMis);
        st_valid = v; st_addr = a; st_data = d; st_size = s; mem_ready = mr; ld_addr = la;
        #1;
        chk("ld_conflict", ld_conflict, conflictModel(la));
        acc = v && sb.size() < DEPTH;
        pendMis = acc && !legal(a, s);
        if (acc && legal(a, s)) sb.push_back(model(a, d, s));
        @(posedge clk); #1;
    endtask

    task automatic doReset();
        reset = 1; st_valid = 0; mem_ready = 0;
        sb.delete();
        pendMis = 0;
        @(posedge clk); #1;
        reset = 0;
    endtask

    always @(negedge clk) begin
        if (!reset && mem_valid) begin
            if (sb.size() == 0) begin
                nChecks++; nFail++;
                $display("FAIL head: mem_valid=1 with addr %0h, expected no pending store", mem_addr);
            end else begin
                chk("mem_addr", mem_addr, sb[0].addr);
                chk("mem_wdata", mem_wdata, sb[0].wdata);
                chk("mem_be", mem_be, sb[0].be);
                if (mem_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        logic acc;
        int tries;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        // 1: byte store at lane 3, visible at head the next cycle
        step(1, 32'h1003, 32'hAABBCC5A, 2'd0, 0, 32'h0, acc);
        step(0, 0, 0, 2'd0, 1, 32'h1000, acc);
        step(0, 0, 0, 2'd0, 0, 32'h0, acc);
        // 2: aligned halfword, then misaligned halfword dropped
        step(1, 32'h2002, 32'h1234BEEF, 2'd1, 1, 32'h0, acc);
        step(0, 0, 0, 2'd0, 1, 32'h0, acc);
        step(1, 32'h2001, 32'h1234BEEF, 2'd1, 1, 32'h0, acc);
        step(0, 0, 0, 2'd0, 1, 32'h2000, acc);
        step(1, 32'h2000, 32'h55, 2'd3, 1, 32'h0, acc);
        step(0, 0, 0, 2'd0, 1, 32'h0, acc);
        // 3+4: fill with memory stalled, full+mem_ready cycle, then drain with wrap
        for (int i = 0; i < 10; i++) begin
            tries = 0;
            do begin
                step(1, 32'h5000 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 2'd2, i >= 4, 32'h5000 + 32'(i * 4), acc);
                tries++;
            end while (!acc && tries < 20);
            if (!acc) begin
                nChecks++; nFail++;
                $display("FAIL fill: store %0d not accepted within %0d cycles", i, tries);
            end
        end
        repeat (DEPTH + 2) step(0, 0, 0, 2'd0, 1, 32'h0, acc);
        // 5: load conflict against pending word store
        step(1, 32'h3008, 32'h0BADF00D, 2'd2, 0, 32'h0, acc);
        step(0, 0, 0, 2'd0, 0, 32'h300B, acc);
        step(0, 0, 0, 2'd0, 0, 32'h300C, acc);
        step(0, 0, 0, 2'd0, 1, 32'h3008, acc);
        step(0, 0, 0, 2'd0, 1, 32'h3008, acc);
        // 6: reset with three pending entries
        for (int i = 0; i < 3; i++) step(1, 32'h6000 + 32'(i), 32'(i), 2'd0, 0, 32'h0, acc);
        doReset();
        step(0, 0, 0, 2'd0, 1, 32'h6000, acc);
        step(0, 0, 0, 2'd0, 1, 32'h0, acc);
        // randomized traffic in a small address window to provoke conflicts
        for (int i = 0; i < 400; i++) begin
            step($urandom % 4 != 0, 32'h4000 + $urandom_range(0, 31), $urandom, 2'($urandom % 4),
                 $urandom % 3 != 0, 32'h4000 + $urandom_range(0, 31), acc);
            if (i == 200) doReset();
        end
        repeat (DEPTH + 2) step(0, 0, 0, 2'd0, 1, 32'h0, acc);
        chk("drained", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
